// File: rtl/prog_loader.sv
// ---------------------------------------------------------------------------
// prog_loader
//   Program loader driven by a UART byte stream. It decodes framed commands
//   (SYNC, CMD, body), writes little-endian words into one of NUM_MEMS target
//   memories, answers each frame with one ACK/NAK byte, and holds the core in
//   reset until a RUN command arrives (HALT re-asserts it). An inter-byte
//   timeout abandons frames that stall.
//
// Ports
//   clk_i        clock
//   rst_i        asynchronous reset, active-high
//   rx_dv_i      one-cycle strobe, rx_byte_i valid
//   rx_byte_i    received byte
//   we_o         one-hot write strobe to the selected memory
//   addr_o       word address for we_o (held between writes)
//   wdata_o      write data for we_o (held between writes)
//   core_rst_no  0 = core held in reset
//   busy_o       frame in progress
//   err_o        sticky error, cleared by the next ACKed frame
//   ack_valid_o  one-cycle strobe, ack_byte_o valid
//   ack_byte_o   8'h06 ACK / 8'h15 NAK
// ---------------------------------------------------------------------------
module prog_loader #(
    parameter int          DATA_W    = 32,
    parameter int          ADDR_W    = 14,
    parameter int          NUM_MEMS  = 2,
    parameter logic [23:0] TIMEOUT   = 24'hFFFFFF,
    parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                rx_dv_i,
    input  logic [7:0]          rx_byte_i,
    output logic [NUM_MEMS-1:0] we_o,
    output logic [ADDR_W-1:0]   addr_o,
    output logic [DATA_W-1:0]   wdata_o,
    output logic                core_rst_no,
    output logic                busy_o,
    output logic                err_o,
    output logic                ack_valid_o,
    output logic [7:0]          ack_byte_o
);

    localparam int BPW   = DATA_W / 8;
    localparam int BCW   = (BPW > 1) ? $clog2(BPW) : 1;
    localparam int TGT_W = (NUM_MEMS > 1) ? $clog2(NUM_MEMS) : 1;

    localparam logic [7:0]          CMD_WRITE = 8'h01;
    localparam logic [7:0]          CMD_RUN   = 8'h02;
    localparam logic [7:0]          CMD_HALT  = 8'h03;
    localparam logic [7:0]          ACK       = 8'h06;
    localparam logic [7:0]          NAK       = 8'h15;
    localparam logic [7:0]          TGT_LIMIT = 8'(NUM_MEMS);
    localparam logic [BCW-1:0]      BCNT_LAST = BCW'(BPW - 1);
    localparam logic [NUM_MEMS-1:0] WE_ONE    = NUM_MEMS'(1);
    // Counter value one idle cycle before the limit is reached.
    localparam logic [23:0]         TMO_LAST  = TIMEOUT - 24'd1;

    typedef enum logic [3:0] {
        S_IDLE, S_CMD, S_TGT, S_AL, S_AH, S_LL, S_LH, S_DATA, S_CSUM
    } state_t;

    state_t            state_q;
    logic [TGT_W-1:0]  tgt_q;
    logic [ADDR_W-1:0] addr_q;     // address of the next word to write
    logic [7:0]        lo_q;       // low byte of ADDR / LEN while the high byte is awaited
    logic [15:0]       len_q;      // words still to receive
    logic [BCW-1:0]    bcnt_q;     // byte position inside the current word
    logic [DATA_W-1:0] word_q;
    logic [7:0]        csum_q;
    logic [23:0]       tmo_q;
    logic [DATA_W-1:0] word_d;

    // Bytes enter at the top and shift down, so the first byte ends in [7:0].
    assign word_d = (word_q >> 8) | (DATA_W'(rx_byte_i) << (DATA_W - 8));
    assign busy_o = (state_q != S_IDLE);

    // NOTE: all state and outputs update with non-blocking assignments so every
    // register in this block sees the pre-edge values of the others.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            tgt_q       <= '0;
            addr_q      <= '0;
            lo_q        <= '0;
            len_q       <= '0;
            bcnt_q      <= '0;
            word_q      <= '0;
            csum_q      <= '0;
            tmo_q       <= '0;
            we_o        <= '0;
            addr_o      <= '0;
            wdata_o     <= '0;
            core_rst_no <= 1'b0;
            err_o       <= 1'b0;
            ack_valid_o <= 1'b0;
            ack_byte_o  <= '0;
        end else begin
            we_o        <= '0;
            ack_valid_o <= 1'b0;
            if (rx_dv_i) begin
                // A byte in the same cycle as the limit wins over the timeout.
                tmo_q <= '0;
                case (state_q)
                    S_IDLE: if (rx_byte_i == SYNC_BYTE) state_q <= S_CMD;
                    S_CMD: begin
                        state_q <= S_IDLE;
                        case (rx_byte_i)
                            CMD_WRITE: state_q <= S_TGT;
                            CMD_RUN, CMD_HALT: begin
                                core_rst_no <= (rx_byte_i == CMD_RUN);
                                ack_valid_o <= 1'b1;
                                ack_byte_o  <= ACK;
                                err_o       <= 1'b0;
                            end
                            default: begin
                                ack_valid_o <= 1'b1;
                                ack_byte_o  <= NAK;
                                err_o       <= 1'b1;
                            end
                        endcase
                    end
                    S_TGT: begin
                        if (rx_byte_i >= TGT_LIMIT) begin
                            // Rest of the frame is dropped by IDLE until the next SYNC.
                            ack_valid_o <= 1'b1;
                            ack_byte_o  <= NAK;
                            err_o       <= 1'b1;
                            state_q     <= S_IDLE;
                        end else begin
                            tgt_q   <= TGT_W'(rx_byte_i);
                            state_q <= S_AL;
                        end
                    end
                    S_AL: begin
                        lo_q    <= rx_byte_i;
                        state_q <= S_AH;
                    end
                    S_AH: begin
                        addr_q  <= ADDR_W'({rx_byte_i, lo_q});
                        state_q <= S_LL;
                    end
                    S_LL: begin
                        lo_q    <= rx_byte_i;
                        state_q <= S_LH;
                    end
                    S_LH: begin
                        len_q   <= {rx_byte_i, lo_q};
                        csum_q  <= '0;
                        bcnt_q  <= '0;
                        state_q <= ({rx_byte_i, lo_q} == 16'd0) ? S_CSUM : S_DATA;
                    end
                    S_DATA: begin
                        csum_q <= csum_q ^ rx_byte_i;
                        word_q <= word_d;
                        if (bcnt_q == BCNT_LAST) begin
                            bcnt_q  <= '0;
                            we_o    <= WE_ONE << tgt_q;
                            addr_o  <= addr_q;
                            wdata_o <= word_d;
                            addr_q  <= addr_q + ADDR_W'(1);
                            len_q   <= len_q - 16'd1;
                            if (len_q == 16'd1) state_q <= S_CSUM;
                        end else begin
                            bcnt_q <= bcnt_q + BCW'(1);
                        end
                    end
                    S_CSUM: begin
                        ack_valid_o <= 1'b1;
                        ack_byte_o  <= (rx_byte_i == csum_q) ? ACK : NAK;
                        err_o       <= (rx_byte_i != csum_q);
                        state_q     <= S_IDLE;
                    end
                    default: state_q <= S_IDLE;
                endcase
            end else if (state_q == S_IDLE) begin
                tmo_q <= '0;
            end else if (TIMEOUT != 24'd0 && tmo_q == TMO_LAST) begin
                ack_valid_o <= 1'b1;
                ack_byte_o  <= NAK;
                err_o       <= 1'b1;
                state_q     <= S_IDLE;
                tmo_q       <= '0;
            end else begin
                tmo_q <= tmo_q + 24'd1;
            end
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader (DATA_W=32, ADDR_W=14, NUM_MEMS=2, TIMEOUT=100).
// Whole frames come from a table; latency, timeout and reset cases are
// written out by hand.
module tb_prog_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx_dv = 1'b0;
    logic [7:0]  rx_byte = 8'h00;
    logic [1:0]  we_o;
    logic [13:0] addr_o;
    logic [31:0] wdata_o;
    logic        core_rst_no, busy_o, err_o, ack_valid_o;
    logic [7:0]  ack_byte_o;

    prog_loader #(
        .DATA_W(32), .ADDR_W(14), .NUM_MEMS(2), .TIMEOUT(24'd100), .SYNC_BYTE(8'hA5)
    ) dut (
        .clk_i(clk), .rst_i(rst), .rx_dv_i(rx_dv), .rx_byte_i(rx_byte),
        .we_o(we_o), .addr_o(addr_o), .wdata_o(wdata_o), .core_rst_no(core_rst_no),
        .busy_o(busy_o), .err_o(err_o), .ack_valid_o(ack_valid_o), .ack_byte_o(ack_byte_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // Monitor: log every write strobe and every ack strobe.
    typedef struct {
        logic [1:0]  we;
        logic [13:0] addr;
        logic [31:0] data;
    } wr_t;
    wr_t        wr_q[$];
    logic [7:0] ack_q[$];

    always @(posedge clk) begin
        #1;
        if (we_o != 2'b00) wr_q.push_back('{we_o, addr_o, wdata_o});
        if (ack_valid_o) ack_q.push_back(ack_byte_o);
    end

    // Byte strobed for one cycle; returns one half-cycle after the sampling edge.
    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_dv   = 1'b1;
        rx_byte = b;
        @(negedge clk);
        rx_dv   = 1'b0;
    endtask

    typedef struct {
        int          start;
        int          len;
        int          nwr;
        logic [1:0]  we;
        logic [13:0] a0;
        logic [31:0] d0;
        logic [13:0] a1;
        logic [31:0] d1;
        logic [7:0]  ack;
        logic        err;
        logic        core;
    } vec_t;

    logic [7:0] pool[$];
    vec_t       vecs[$];

    task automatic add_vec(input int mark, input int nwr, input logic [1:0] we,
                           input logic [13:0] a0, input logic [31:0] d0,
                           input logic [13:0] a1, input logic [31:0] d1,
                           input logic [7:0] ack, input logic err, input logic core);
        vecs.push_back('{mark, pool.size() - mark, nwr, we, a0, d0, a1, d1, ack, err, core});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int mark;

        // Frame table. Checksums are the XOR of the data bytes.
        mark = pool.size();  // two words to mem 0; csum EF^BE^AD^DE^78^56^34^12 = 2A
        pool = {pool, 8'hA5, 8'h01, 8'h00, 8'h10, 8'h00, 8'h02, 8'h00,
                8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h78, 8'h56, 8'h34, 8'h12, 8'h2A};
        add_vec(mark, 2, 2'b01, 14'h0010, 32'hDEADBEEF, 14'h0011, 32'h12345678, 8'h06, 1'b0, 1'b0);
        mark = pool.size();  // same to mem 1, bad checksum: words still written
        pool = {pool, 8'hA5, 8'h01, 8'h01, 8'h10, 8'h00, 8'h02, 8'h00,
                8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h78, 8'h56, 8'h34, 8'h12, 8'h55};
        add_vec(mark, 2, 2'b10, 14'h0010, 32'hDEADBEEF, 14'h0011, 32'h12345678, 8'h15, 1'b1, 1'b0);
        mark = pool.size();  // LEN=0, csum 00 -> ACK clears err
        pool = {pool, 8'hA5, 8'h01, 8'h01, 8'h20, 8'h00, 8'h00, 8'h00, 8'h00};
        add_vec(mark, 0, 2'b00, 14'h0000, 32'h0, 14'h0000, 32'h0, 8'h06, 1'b0, 1'b0);
        mark = pool.size();  // bad target: NAK, trailing bytes ignored
        pool = {pool, 8'hA5, 8'h01, 8'h02, 8'h10, 8'h00, 8'h01, 8'h00,
                8'h11, 8'h22, 8'h33, 8'h44, 8'h00};
        add_vec(mark, 0, 2'b00, 14'h0000, 32'h0, 14'h0000, 32'h0, 8'h15, 1'b1, 1'b0);
        mark = pool.size();  // address wrap 3FFF -> 0000; csum 08
        pool = {pool, 8'hA5, 8'h01, 8'h00, 8'hFF, 8'h3F, 8'h02, 8'h00,
                8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h08};
        add_vec(mark, 2, 2'b01, 14'h3FFF, 32'h04030201, 14'h0000, 32'h08070605, 8'h06, 1'b0, 1'b0);
        mark = pool.size();  // garbage before SYNC, then RUN
        pool = {pool, 8'h33, 8'h44, 8'hA5, 8'h02};
        add_vec(mark, 0, 2'b00, 14'h0000, 32'h0, 14'h0000, 32'h0, 8'h06, 1'b0, 1'b1);
        mark = pool.size();  // RUN again: still ACKed
        pool = {pool, 8'hA5, 8'h02};
        add_vec(mark, 0, 2'b00, 14'h0000, 32'h0, 14'h0000, 32'h0, 8'h06, 1'b0, 1'b1);
        mark = pool.size();  // unknown command, core stays running
        pool = {pool, 8'hA5, 8'h07};
        add_vec(mark, 0, 2'b00, 14'h0000, 32'h0, 14'h0000, 32'h0, 8'h15, 1'b1, 1'b1);
        mark = pool.size();  // HALT
        pool = {pool, 8'hA5, 8'h03};
        add_vec(mark, 0, 2'b00, 14'h0000, 32'h0, 14'h0000, 32'h0, 8'h06, 1'b0, 1'b0);
        mark = pool.size();  // unknown command, core stays halted
        pool = {pool, 8'hA5, 8'h07};
        add_vec(mark, 0, 2'b00, 14'h0000, 32'h0, 14'h0000, 32'h0, 8'h15, 1'b1, 1'b0);

        // Reset state
        @(negedge clk);
        check("rst we_o",        32'(we_o), 32'h0);
        check("rst addr_o",      32'(addr_o), 32'h0);
        check("rst wdata_o",     wdata_o, 32'h0);
        check("rst core_rst_no", 32'(core_rst_no), 32'h0);
        check("rst busy_o",      32'(busy_o), 32'h0);
        check("rst err_o",       32'(err_o), 32'h0);
        check("rst ack_valid_o", 32'(ack_valid_o), 32'h0);
        check("rst ack_byte_o",  32'(ack_byte_o), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Table-driven frames
        for (int v = 0; v < vecs.size(); v++) begin
            wr_q.delete();
            ack_q.delete();
            for (int i = 0; i < vecs[v].len; i++) send_byte(pool[vecs[v].start + i]);
            repeat (3) @(negedge clk);
            check($sformatf("v%0d write count", v), 32'(wr_q.size()), 32'(vecs[v].nwr));
            if (vecs[v].nwr >= 1 && wr_q.size() >= 1) begin
                check($sformatf("v%0d w0 we", v),   32'(wr_q[0].we), 32'(vecs[v].we));
                check($sformatf("v%0d w0 addr", v), 32'(wr_q[0].addr), 32'(vecs[v].a0));
                check($sformatf("v%0d w0 data", v), wr_q[0].data, vecs[v].d0);
            end
            if (vecs[v].nwr >= 2 && wr_q.size() >= 2) begin
                check($sformatf("v%0d w1 we", v),   32'(wr_q[1].we), 32'(vecs[v].we));
                check($sformatf("v%0d w1 addr", v), 32'(wr_q[1].addr), 32'(vecs[v].a1));
                check($sformatf("v%0d w1 data", v), wr_q[1].data, vecs[v].d1);
            end
            check($sformatf("v%0d ack count", v), 32'(ack_q.size()), 32'd1);
            if (ack_q.size() >= 1)
                check($sformatf("v%0d ack byte", v), 32'(ack_q[0]), 32'(vecs[v].ack));
            check($sformatf("v%0d err_o", v),       32'(err_o), 32'(vecs[v].err));
            check($sformatf("v%0d core_rst_no", v), 32'(core_rst_no), 32'(vecs[v].core));
            check($sformatf("v%0d busy_o", v),      32'(busy_o), 32'h0);
        end

        // Latency: write and ack appear one cycle after the strobing byte,
        // last for one cycle, and addr/wdata hold afterwards.
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h01); send_byte(8'h05);
        send_byte(8'h00); send_byte(8'h01); send_byte(8'h00);
        send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC);
        check("lat no early we", 32'(we_o), 32'h0);
        send_byte(8'hDD);
        check("lat we_o",    32'(we_o), 32'h2);
        check("lat addr_o",  32'(addr_o), 32'h0005);
        check("lat wdata_o", wdata_o, 32'hDDCCBBAA);
        @(negedge clk);
        check("lat we one cycle", 32'(we_o), 32'h0);
        check("lat addr hold",    32'(addr_o), 32'h0005);
        check("lat wdata hold",   wdata_o, 32'hDDCCBBAA);
        send_byte(8'h00);  // AA^BB^CC^DD = 00
        check("lat ack_valid", 32'(ack_valid_o), 32'h1);
        check("lat ack_byte",  32'(ack_byte_o), 32'h06);
        @(negedge clk);
        check("lat ack one cycle", 32'(ack_valid_o), 32'h0);

        // Reset mid-DATA: outputs return to reset values, frame is lost.
        send_byte(8'hA5); send_byte(8'h02);   // core running
        send_byte(8'hA5); send_byte(8'h07);   // err set, last ack byte NAK
        wr_q.delete();
        ack_q.delete();
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00); send_byte(8'h10);
        send_byte(8'h00); send_byte(8'h01); send_byte(8'h00);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
        check("pre-rst busy_o", 32'(busy_o), 32'h1);
        rst = 1'b1;
        #1;
        check("mid rst we_o",        32'(we_o), 32'h0);
        check("mid rst addr_o",      32'(addr_o), 32'h0);
        check("mid rst wdata_o",     wdata_o, 32'h0);
        check("mid rst core_rst_no", 32'(core_rst_no), 32'h0);
        check("mid rst busy_o",      32'(busy_o), 32'h0);
        check("mid rst err_o",       32'(err_o), 32'h0);
        check("mid rst ack_byte_o",  32'(ack_byte_o), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        send_byte(8'h44); send_byte(8'h00);
        repeat (3) @(negedge clk);
        check("post rst writes", 32'(wr_q.size()), 32'd0);
        check("post rst acks",   32'(ack_q.size()), 32'd0);

        // Timeout: 100 idle cycles after AL -> NAK on the 100th.
        ack_q.delete();
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00); send_byte(8'h10);
        repeat (99) @(posedge clk);
        #1;
        check("tmo none at 99", 32'(ack_q.size()), 32'd0);
        check("tmo busy at 99", 32'(busy_o), 32'h1);
        @(posedge clk);
        #1;
        check("tmo ack_valid", 32'(ack_valid_o), 32'h1);
        check("tmo ack_byte",  32'(ack_byte_o), 32'h15);
        check("tmo busy_o",    32'(busy_o), 32'h0);
        check("tmo err_o",     32'(err_o), 32'h1);

        // Byte arriving on the limit cycle wins.
        @(negedge clk);
        ack_q.delete();
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00); send_byte(8'h10);
        repeat (99) @(posedge clk);
        @(negedge clk);
        rx_dv   = 1'b1;
        rx_byte = 8'h00;
        @(negedge clk);
        rx_dv   = 1'b0;
        check("edge no timeout", 32'(ack_q.size()), 32'd0);
        check("edge busy_o",     32'(busy_o), 32'h1);
        send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        repeat (2) @(negedge clk);
        check("edge ack count", 32'(ack_q.size()), 32'd1);
        if (ack_q.size() >= 1) check("edge ack byte", 32'(ack_q[0]), 32'h06);
        check("edge err_o", 32'(err_o), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
